// File: rtl/frame_swap_buffer_if.sv
// Write-side handshake between the drawing engine (master) and frame_swap_buffer (slave).
interface frame_swap_buffer_if #(
  parameter int PIX_W = 5
) ();
  logic             wr_valid;
  logic             wr_ready;
  logic [9:0]       wr_x;
  logic [9:0]       wr_y;
  logic [PIX_W-1:0] wr_data;

  modport master (output wr_valid, wr_x, wr_y, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_x, wr_y, wr_data, output wr_ready);
endinterface

// File: rtl/frame_swap_buffer.sv
// Double-buffered window framebuffer: the display reads the front buffer while the writer
// fills the back buffer; buffers swap at vertical blanking, optionally clearing the new back one.
module frame_swap_buffer #(
  parameter int               PIX_W     = 5,
  parameter int               WIN_X     = 0,
  parameter int               WIN_Y     = 0,
  parameter int               WIN_W     = 24,
  parameter int               WIN_H     = 45,
  parameter logic [PIX_W-1:0] TRANSP    = PIX_W'(21),
  parameter logic [PIX_W-1:0] BG_VAL    = '0,
  parameter bit               CLEAR_EN  = 1'b1,
  parameter logic [PIX_W-1:0] CLEAR_VAL = '0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               VS,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic [PIX_W-1:0]   pixelOut,
  input  logic               swap_req,
  output logic               swap_done,
  output logic               front_sel,
  output logic [7:0]         frame_cnt,
  frame_swap_buffer_if.slave wr
);

  localparam int              DEPTH = WIN_W * WIN_H;
  localparam int              AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [19:0]     X0    = 20'(WIN_X);
  localparam logic [19:0]     Y0    = 20'(WIN_Y);
  localparam logic [19:0]     XW    = 20'(WIN_W);
  localparam logic [19:0]     YH    = 20'(WIN_H);
  localparam logic [AW-1:0]   LAST  = AW'(DEPTH - 1);

  typedef enum logic {DISPLAY, CLEAR} state_t;

  function automatic logic inWin(input logic [9:0] x, input logic [9:0] y);
    logic [19:0] xe;
    logic [19:0] ye;
    xe = {10'd0, x};
    ye = {10'd0, y};
    return (xe >= X0) && (xe < X0 + XW) && (ye >= Y0) && (ye < Y0 + YH);
  endfunction

  function automatic logic [AW-1:0] winAddr(input logic [9:0] x, input logic [9:0] y);
    logic [19:0] lin;
    lin = ({10'd0, x} - X0) + ({10'd0, y} - Y0) * XW;
    return AW'(lin);
  endfunction

  logic [PIX_W-1:0] bufA [DEPTH];
  logic [PIX_W-1:0] bufB [DEPTH];

  state_t        state, stateNext;
  logic          vsQ, pending, vblankEdge, swapNow, clrLast, wrReady, wrFire, rdHit;
  logic [AW-1:0] clrCnt, wrAddr, rdAddr;

  assign vblankEdge  = vsQ && !VS;
  assign clrLast     = (clrCnt == LAST);
  // Ready drops in CLEAR and in the cycle swap_done is shown.
  assign wrReady     = (state == DISPLAY) && !swap_done;
  assign wr.wr_ready = wrReady;
  assign wrAddr      = winAddr(wr.wr_x, wr.wr_y);
  assign wrFire      = wr.wr_valid && wrReady && (wr.wr_data != TRANSP) && inWin(wr.wr_x, wr.wr_y);
  assign rdHit       = inWin(DrawX, DrawY);
  assign rdAddr      = winAddr(DrawX, DrawY);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset) state <= DISPLAY;
    else        state <= stateNext;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext = state;
    swapNow   = 1'b0;
    case (state)
      DISPLAY: begin
        if (vblankEdge && (pending || swap_req)) begin
          swapNow = 1'b1;
          if (CLEAR_EN) stateNext = CLEAR;
        end
      end
      CLEAR:   if (clrLast) stateNext = DISPLAY;
      default: stateNext = DISPLAY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      front_sel <= 1'b0;
      pending   <= 1'b0;
      vsQ       <= 1'b1;
      swap_done <= 1'b0;
      frame_cnt <= 8'd0;
      clrCnt    <= '0;
      pixelOut  <= BG_VAL;
    end else begin
      vsQ       <= VS;
      swap_done <= swapNow;
      if (swapNow) begin
        front_sel <= ~front_sel;
        frame_cnt <= frame_cnt + 8'd1;
        pending   <= 1'b0;
      end else if (swap_req) begin
        pending <= 1'b1;
      end
      if (state == CLEAR && !clrLast) clrCnt <= clrCnt + 1'b1;
      else                            clrCnt <= '0;
      // front_sel here is the pre-edge value, so reads follow a toggle one cycle later.
      if (!rdHit)         pixelOut <= BG_VAL;
      else if (front_sel) pixelOut <= bufB[rdAddr];
      else                pixelOut <= bufA[rdAddr];
    end
  end

  // NOTE: the buffers have no reset: contents are don't-care until written or cleared,
  // and a reset would stop them mapping onto block RAM. Writes are only held off during reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      if (state == CLEAR) begin
        if (front_sel) bufA[clrCnt] <= CLEAR_VAL;
        else           bufB[clrCnt] <= CLEAR_VAL;
      end else if (wrFire) begin
        if (front_sel) bufA[wrAddr] <= wr.wr_data;
        else           bufB[wrAddr] <= wr.wr_data;
      end
    end
  end

endmodule

// File: tb/tb_frame_swap_buffer.sv
// Scoreboard bench for frame_swap_buffer: reads and swaps are queued when issued and
// matched by a monitor; a second instance with CLEAR_EN=0 covers frame counter wrap.
module tb_frame_swap_buffer;

  typedef struct { logic [4:0] val; string tag; }              pix_exp_t;
  typedef struct { logic fsel; logic [7:0] cnt; string tag; }  swap_exp_t;

  logic       Clk = 1'b0;
  logic       Reset, VS, swap_req, swap_done, front_sel;
  logic [9:0] DrawX, DrawY;
  logic [4:0] pixelOut;
  logic [7:0] frame_cnt;

  logic       VS2, swapReq2, swapDone2, frontSel2;
  logic [4:0] pixelOut2;
  logic [7:0] frameCnt2;

  frame_swap_buffer_if #(.PIX_W(5)) wrIf ();
  frame_swap_buffer_if #(.PIX_W(5)) wrIf2 ();

  frame_swap_buffer #(.PIX_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .VS(VS), .DrawX(DrawX), .DrawY(DrawY),
    .pixelOut(pixelOut), .swap_req(swap_req), .swap_done(swap_done),
    .front_sel(front_sel), .frame_cnt(frame_cnt), .wr(wrIf)
  );

  frame_swap_buffer #(.PIX_W(5), .BG_VAL(5'h1E), .CLEAR_EN(1'b0)) dut2 (
    .Clk(Clk), .Reset(Reset), .VS(VS2), .DrawX(DrawX), .DrawY(DrawY),
    .pixelOut(pixelOut2), .swap_req(swapReq2), .swap_done(swapDone2),
    .front_sel(frontSel2), .frame_cnt(frameCnt2), .wr(wrIf2)
  );

  always #5 Clk = ~Clk;

  int        nChecks = 0;
  int        nFails  = 0;
  pix_exp_t  pixQ[$];
  swap_exp_t swapQ[$];
  pix_exp_t  pe;
  swap_exp_t se;
  logic      rdReq  = 1'b0;
  logic      rdPipe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Read results appear one cycle after the coordinates are presented.
  always @(posedge Clk) rdPipe <= rdReq;

  always @(negedge Clk) begin
    if (rdPipe) begin
      if (pixQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL pixel scoreboard: read result %0h with nothing expected", pixelOut);
      end else begin
        pe = pixQ.pop_front();
        check(pe.tag, 32'(pixelOut), 32'(pe.val));
      end
    end
    if (swap_done !== 1'b0) begin
      if (swapQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected swap_done: front_sel %0h frame_cnt %0h", front_sel, frame_cnt);
      end else begin
        se = swapQ.pop_front();
        check({se.tag, " front_sel"}, 32'(front_sel), 32'(se.fsel));
        check({se.tag, " frame_cnt"}, 32'(frame_cnt), 32'(se.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", nChecks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic wrPix(input int x, input int y, input logic [4:0] d, input string tag);
    check({tag, " wr_ready"}, 32'(wrIf.wr_ready), 1);
    wrIf.wr_valid = 1'b1;
    wrIf.wr_x     = 10'(x);
    wrIf.wr_y     = 10'(y);
    wrIf.wr_data  = d;
    tick();
    wrIf.wr_valid = 1'b0;
  endtask

  task automatic rdPix(input int x, input int y, input logic [4:0] v, input string tag);
    DrawX = 10'(x);
    DrawY = 10'(y);
    rdReq = 1'b1;
    pixQ.push_back('{val: v, tag: tag});
    tick();
    rdReq = 1'b0;
    DrawX = 10'd1023;
    DrawY = 10'd1023;
  endtask

  task automatic expectSwap(input logic fs, input logic [7:0] c, input string tag);
    swapQ.push_back('{fsel: fs, cnt: c, tag: tag});
  endtask

  task automatic waitReady(output int n);
    n = 0;
    while (wrIf.wr_ready !== 1'b1 && n < 3000) begin
      n++;
      tick();
    end
    check("wr_ready returned within bound", 32'(n < 3000), 1);
  endtask

  initial begin
    int n;
    int bad;
    Reset = 1'b0; VS = 1'b1; swap_req = 1'b0; DrawX = 10'd1023; DrawY = 10'd1023;
    wrIf.wr_valid = 1'b0; wrIf.wr_x = '0; wrIf.wr_y = '0; wrIf.wr_data = '0;
    VS2 = 1'b1; swapReq2 = 1'b0;
    wrIf2.wr_valid = 1'b0; wrIf2.wr_x = '0; wrIf2.wr_y = '0; wrIf2.wr_data = '0;
    tick();
    tick();
    check("reset front_sel", 32'(front_sel), 0);
    check("reset frame_cnt", 32'(frame_cnt), 0);
    check("reset swap_done", 32'(swap_done), 0);
    check("reset pixelOut", 32'(pixelOut), 0);
    check("reset wr_ready", 32'(wrIf.wr_ready), 1);
    check("dut2 reset pixelOut", 32'(pixelOut2), 32'h1E);
    check("dut2 reset frame_cnt", 32'(frameCnt2), 0);
    check("dut2 reset wr_ready", 32'(wrIf2.wr_ready), 1);
    Reset = 1'b1;
    tick();

    // First swap: back buffer B becomes front, A is cleared.
    wrPix(3, 2, 5'h07, "write (3,2)");
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    VS = 1'b0;
    check("decision cycle wr_ready", 32'(wrIf.wr_ready), 1);
    wrIf.wr_valid = 1'b1; wrIf.wr_x = 10'd5; wrIf.wr_y = 10'd5; wrIf.wr_data = 5'h0A;
    expectSwap(1'b1, 8'd1, "swap1");
    tick();
    wrIf.wr_valid = 1'b0;
    check("swap1 front_sel held", 32'(front_sel), 1);
    waitReady(n);
    check("swap1 clear length", n, 1080);
    rdPix(3, 2, 5'h07, "read (3,2) after swap1");
    rdPix(5, 5, 5'h0A, "write in toggle cycle hits old back");

    // Transparent and out-of-window writes into back buffer A.
    wrPix(3, 2, 5'h07, "write A (3,2)");
    wrPix(3, 2, 5'h15, "transparent write");
    wrPix(30, 2, 5'h09, "outside write");
    rdPix(30, 2, 5'h00, "read outside window");
    rdPix(3, 2, 5'h07, "front B unchanged");
    swap_req = 1'b1; VS = 1'b1;
    tick();
    swap_req = 1'b0; VS = 1'b0;
    expectSwap(1'b0, 8'd2, "swap2");
    tick();
    waitReady(n);
    check("swap2 clear length", n, 1080);
    rdPix(3, 2, 5'h07, "transparent discarded");
    rdPix(6, 3, 5'h00, "outside write not aliased");
    rdPix(0, 0, 5'h00, "clear first address");
    rdPix(23, 44, 5'h00, "clear last address");
    rdPix(24, 0, 5'h00, "right edge is background");
    rdPix(0, 45, 5'h00, "bottom edge is background");

    // Blanking edge without a request, then collapsed requests.
    wrPix(10, 40, 5'h1F, "write B (10,40)");
    VS = 1'b1;
    tick();
    VS = 1'b0;
    tick();
    check("idle edge front_sel", 32'(front_sel), 0);
    check("idle edge frame_cnt", 32'(frame_cnt), 2);
    check("idle edge swap_done", 32'(swap_done), 0);
    check("idle edge wr_ready", 32'(wrIf.wr_ready), 1);
    VS = 1'b1;
    for (int k = 0; k < 3; k++) begin
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      tick();
    end
    VS = 1'b0;
    expectSwap(1'b1, 8'd3, "swap3 collapsed");
    tick();

    // Request and blanking edge inside CLEAR, write held pending.
    check("clear3 wr_ready a", 32'(wrIf.wr_ready), 0);
    swap_req = 1'b1;
    wrIf.wr_valid = 1'b1; wrIf.wr_x = 10'd1; wrIf.wr_y = 10'd1; wrIf.wr_data = 5'h03;
    tick();
    check("clear3 wr_ready b", 32'(wrIf.wr_ready), 0);
    swap_req = 1'b0;
    VS = 1'b1;
    tick();
    check("clear3 wr_ready c", 32'(wrIf.wr_ready), 0);
    VS = 1'b0;
    tick();
    waitReady(n);
    check("clear3 length", n + 3, 1080);
    check("no swap in clear front_sel", 32'(front_sel), 1);
    check("no swap in clear frame_cnt", 32'(frame_cnt), 3);
    tick();
    wrIf.wr_valid = 1'b0;
    VS = 1'b1;
    tick();
    VS = 1'b0;
    expectSwap(1'b0, 8'd4, "swap4 latched request");
    tick();
    rdPix(1, 1, 5'h03, "write after clear");
    rdPix(3, 2, 5'h00, "clear wiped old pixel");

    // Reset part-way through clearing B.
    VS = 1'b1;
    repeat (100) tick();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    check("mid-clear reset front_sel", 32'(front_sel), 0);
    check("mid-clear reset frame_cnt", 32'(frame_cnt), 0);
    check("mid-clear reset swap_done", 32'(swap_done), 0);
    check("mid-clear reset pixelOut", 32'(pixelOut), 0);
    check("mid-clear reset wr_ready", 32'(wrIf.wr_ready), 1);
    tick();
    swap_req = 1'b1;
    VS = 1'b0;
    expectSwap(1'b1, 8'd1, "swap with same-cycle request");
    tick();
    swap_req = 1'b0;
    rdPix(10, 40, 5'h1F, "reset stopped clear");
    rdPix(0, 0, 5'h00, "cleared before reset");
    waitReady(n);

    // No-clear instance: background value and 256 swaps.
    DrawX = 10'd24; DrawY = 10'd0;
    tick();
    check("dut2 right edge background", 32'(pixelOut2), 32'h1E);
    DrawX = 10'd5; DrawY = 10'd45;
    tick();
    check("dut2 bottom edge background", 32'(pixelOut2), 32'h1E);
    DrawX = 10'd1023; DrawY = 10'd1023;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      swapReq2 = 1'b1; VS2 = 1'b1;
      tick();
      swapReq2 = 1'b0; VS2 = 1'b0;
      tick();
      if (!(swapDone2 === 1'b1 && wrIf2.wr_ready === 1'b0 &&
            frameCnt2 === 8'(i + 1) && frontSel2 === ~i[0])) bad++;
      VS2 = 1'b1;
      tick();
      if (!(swapDone2 === 1'b0 && wrIf2.wr_ready === 1'b1)) bad++;
      if (i == 127) check("dut2 frame_cnt after 128 swaps", 32'(frameCnt2), 128);
    end
    check("dut2 swap cycles with wrong outputs", bad, 0);
    check("dut2 frame_cnt wrapped", 32'(frameCnt2), 0);
    check("dut2 front_sel after 256 swaps", 32'(frontSel2), 0);

    tick();
    check("pixel expectations left over", pixQ.size(), 0);
    check("swap expectations left over", swapQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/frame_swap_buffer.md
FRAME_SWAP_BUFFER -- requirements
Module: frame_swap_buffer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- PIX_W, 5: pixel code width.
- WIN_X, 0: window left edge (screen X).
- WIN_Y, 0: window top edge (screen Y).
- WIN_W, 24: window width in pixels.
- WIN_H, 45: window height in pixels.
- TRANSP, 5'h15: transparent code, never written.
- BG_VAL, 0: pixel output outside the window.
- CLEAR_EN, 1: clear the new back buffer after each swap.
- CLEAR_VAL, 0: value written during clear.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- Clk, in, 1: single clock; all logic on its rising edge.
- Reset, in, 1: synchronous, active-low reset.
- VS, in, 1: vertical sync; low means vertical blanking.
- DrawX, in, 10: display read X.
- DrawY, in, 10: display read Y.
- pixelOut, out, PIX_W: registered front-buffer pixel.
- wr_valid, in, 1: write request.
- wr_ready, out, 1: write port accepts requests.
- wr_x, in, 10: write X.
- wr_y, in, 10: write Y.
- wr_data, in, PIX_W: write pixel.
- swap_req, in, 1: writer has finished the frame; one-cycle pulse.
- swap_done, out, 1: one-cycle pulse when a swap takes effect.
- front_sel, out, 1: 0 means buffer A is displayed, 1 means buffer B is displayed.
- frame_cnt, out, 8: completed swap count.

Function
REQ-003 The block SHALL hold two WIN_W*WIN_H x PIX_W buffers, A and B.
- Window address = (x-WIN_X) + (y-WIN_Y)*WIN_W.
- Arithmetic SHALL be at least 20 bits wide.
REQ-004 Read path: pixelOut SHALL be the front-buffer value at (DrawX, DrawY) exactly 1 Clk after DrawX/DrawY are presented.
REQ-005 Read path: a read coordinate outside [WIN_X, WIN_X+WIN_W) x [WIN_Y, WIN_Y+WIN_H) SHALL produce BG_VAL with the same 1-cycle latency, and no buffer access.
REQ-006 Write path: a write SHALL occur only when wr_valid=1 and wr_ready=1 in the same cycle, and only to the back buffer (the one not selected by front_sel).
REQ-007 Write path: an accepted write with wr_data==TRANSP, or with coordinates outside the window, SHALL be discarded with no buffer change.
REQ-008 The front buffer SHALL never be written.
REQ-009 FSM states SHALL be DISPLAY, CLEAR.
- VS is registered once.
- vblank_edge = (VS_q==1 && VS==0).
REQ-010 swap_req SHALL set a pending flag in any state; repeated requests before service collapse into one.
REQ-011 In DISPLAY, on vblank_edge with pending=1 (including pending set in that same cycle), the block SHALL in the next cycle:
- toggle front_sel;
- clear pending;
- pulse swap_done for 1 cycle;
- increment frame_cnt (mod 256);
- enter CLEAR if CLEAR_EN=1, else stay in DISPLAY.
REQ-012 On vblank_edge with pending=0, the block SHALL make no change.
REQ-013 CLEAR SHALL write CLEAR_VAL to back-buffer addresses 0..WIN_W*WIN_H-1, one per cycle, ascending, then return to DISPLAY.
- CLEAR lasts exactly WIN_W*WIN_H cycles.
REQ-014 wr_ready SHALL be 0 in CLEAR and in the swap cycle; it SHALL be 1 otherwise.
REQ-015 A vblank_edge during CLEAR SHALL NOT swap. Pending stays latched and is serviced at the first vblank_edge after CLEAR ends.
REQ-016 A write accepted in the same cycle that front_sel toggles SHALL target the pre-toggle back buffer.
REQ-017 Reads SHALL use the post-toggle front_sel from the cycle after the toggle.

Reset
REQ-018 While Reset=0 at a Clk edge, the block SHALL set:
- state = DISPLAY, front_sel = 0, pending = 0, VS_q = 1;
- swap_done = 0, frame_cnt = 0, pixelOut = BG_VAL, wr_ready = 1;
- clear counter = 0.
REQ-019 Buffer contents SHALL be unspecified after reset.
REQ-020 Reset asserted during CLEAR SHALL abort the clear and return to DISPLAY per REQ-018.

Verification (defaults, CLEAR_EN=1 unless stated)
REQ-021 Scenario: write (3,2)=5'h07; swap_req; VS 1->0.
- swap_done pulses.
- front_sel=1.
- CLEAR runs 1080 cycles.
- Reading (3,2) returns 5'h07 one cycle later.
REQ-022 Scenario: write (3,2)=5'h15 over an existing 5'h07.
- Back-buffer value stays 5'h07, verified after the next swap.
- Write (30,2)=5'h09: no change anywhere.
- Reading (30,2) returns BG_VAL.
REQ-023 Scenario: VS 1->0 with no swap_req.
- front_sel, frame_cnt and swap_done are unchanged.
- Three swap_req pulses then one edge give exactly one swap; frame_cnt=1.
REQ-024 Scenario: swap_req during CLEAR, plus a vblank_edge during CLEAR.
- No swap occurs during CLEAR.
- wr_valid held high is not accepted until CLEAR ends.
- The next vblank_edge after CLEAR swaps.
REQ-025 Scenario: Reset low 1 cycle mid-CLEAR.
- All outputs match REQ-018 the following cycle.
- No further clear writes occur.
REQ-026 Scenario: 256 swaps.
- frame_cnt wraps to 0.
- front_sel ends at 0.
- With CLEAR_EN=0, each swap returns directly to DISPLAY with wr_ready=0 for only the swap cycle.
